// File: rtl/writeback_arbiter.sv
// Round-robin arbiter sharing the register file write ports among result producers.
// Grants to distinct registers only; granted results are registered onto the write ports.
module writeback_arbiter #(
  parameter int SIZE            = 32,
  parameter int REGISTER_COUNT  = 31,
  parameter int REQUESTER_COUNT = 4,
  parameter int WRITE_COUNT     = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic hold,
  input  logic [REQUESTER_COUNT-1:0] request_valid,
  input  logic [$clog2(REGISTER_COUNT)*REQUESTER_COUNT-1:0] request_index,
  input  logic [SIZE*REQUESTER_COUNT-1:0] request_data,
  output logic [REQUESTER_COUNT-1:0] request_ready,
  output logic [WRITE_COUNT-1:0] write_enable,
  output logic [$clog2(REGISTER_COUNT)*WRITE_COUNT-1:0] write_index,
  output logic [SIZE*WRITE_COUNT-1:0] write_data,
  output logic [$clog2(WRITE_COUNT+1)-1:0] grant_count
);

  localparam int REGISTER_INDEX_SIZE = $clog2(REGISTER_COUNT);
  localparam int IW = REGISTER_INDEX_SIZE;
  localparam int PW = (REQUESTER_COUNT > 1) ? $clog2(REQUESTER_COUNT) : 1;
  localparam int CW = $clog2(WRITE_COUNT + 1);

  logic [PW-1:0] pointer;
  logic [PW-1:0] pointer_next;
  logic [WRITE_COUNT-1:0] port_enable;
  logic [IW-1:0] port_index [WRITE_COUNT];
  logic [SIZE-1:0] port_data [WRITE_COUNT];
  logic [CW-1:0] count;

  always_comb begin
    logic [PW-1:0] r;
    logic [IW-1:0] idx;
    logic clash;
    request_ready = '0;
    port_enable = '0;
    for (int k = 0; k < WRITE_COUNT; k++) begin
      port_index[k] = '0;
      port_data[k] = '0;
    end
    count = '0;
    pointer_next = pointer;
    r = '0;
    idx = '0;
    clash = 1'b0;
    if (!reset && !hold) begin
      for (int j = 0; j < REQUESTER_COUNT; j++) begin
        r = PW'((int'(pointer) + j) % REQUESTER_COUNT);
        idx = request_index[int'(r)*IW +: IW];
        clash = 1'b0;
        // only ports already filled this cycle can collide
        for (int k = 0; k < WRITE_COUNT; k++)
          if (port_enable[k] && port_index[k] == idx)
            clash = 1'b1;
        if (request_valid[r] && count < CW'(WRITE_COUNT) && !clash) begin
          request_ready[r] = 1'b1;
          for (int k = 0; k < WRITE_COUNT; k++)
            if (count == CW'(k)) begin
              port_enable[k] = 1'b1;
              port_index[k] = idx;
              port_data[k] = request_data[int'(r)*SIZE +: SIZE];
            end
          count = count + CW'(1);
          pointer_next = PW'((int'(r) + 1) % REQUESTER_COUNT);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pointer <= '0;
      write_enable <= '0;
      write_index <= '0;
      write_data <= '0;
      grant_count <= '0;
    end else begin
      pointer <= pointer_next;
      write_enable <= port_enable;
      grant_count <= count;
      for (int k = 0; k < WRITE_COUNT; k++)
        if (port_enable[k]) begin
          write_index[k*IW +: IW] <= port_index[k];
          write_data[k*SIZE +: SIZE] <= port_data[k];
        end
    end
  end

`ifndef SYNTHESIS
  logic [REQUESTER_COUNT-1:0] stall_q;
  logic [IW*REQUESTER_COUNT-1:0] index_q;
  logic [SIZE*REQUESTER_COUNT-1:0] data_q;

  always_ff @(posedge clock) begin
    stall_q <= reset ? '0 : (request_valid & ~request_ready);
    index_q <= request_index;
    data_q <= request_data;
    for (int i = 0; i < REQUESTER_COUNT; i++)
      if (!reset && stall_q[i])
        assert (request_valid[i]
                && request_index[i*IW +: IW] == index_q[i*IW +: IW]
                && request_data[i*SIZE +: SIZE] == data_q[i*SIZE +: SIZE])
        else $error("requester %0d changed while stalled", i);
    for (int a = 0; a < WRITE_COUNT; a++)
      for (int b = a + 1; b < WRITE_COUNT; b++)
        if (write_enable[a] && write_enable[b])
          assert (write_index[a*IW +: IW] != write_index[b*IW +: IW])
          else $error("write ports %0d and %0d hit the same register", a, b);
  end
`endif

endmodule
